iic_scl_timer: RTL and testbench

- Runtime-programmable SCL timing generator for the IIC master. Successor to the fixed-divide phase generator.
- Produces the SCL drive level plus phase strobes (rise, high_mid, fall, low_mid, period_done) that the bit-level FSM uses to time SDA changes and sampling.
- Adds three things the fixed generator lacks: a divisor reloaded at run time, slave clock-stretch detection, and a stretch timeout.

---
 rtl/iic_pkg.sv | 21 ++
 rtl/iic_stretch_monitor.sv | 58 +++++
 rtl/iic_scl_timer.sv | 154 +++++++++++++++
 tb/tb_iic_scl_timer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared types and constants for the IIC master timing blocks.
//   iic_div_t   : SCL divisor / phase counter word at the default width
//   IIC_MIN_DIV : smallest divisor ever applied (smaller loads are raised to it)
//   iic_phase_t : bundle of single-cycle SCL phase strobes
package iic_pkg;

  localparam int unsigned IIC_CNT_W = 16;

  typedef logic [IIC_CNT_W-1:0] iic_div_t;

  localparam int unsigned IIC_MIN_DIV = 4;

  typedef struct packed {
    logic rise;
    logic high_mid;
    logic fall;
    logic low_mid;
    logic period_done;
  } iic_phase_t;

endpackage

// File: rtl/iic_stretch_monitor.sv
// Slave clock-stretch monitor for the SCL timer.
// Requests a counter hold while SCL is released at the start of a period but the bus is
// still low, counts held cycles and flags a sticky timeout.
//   clk, rst_n  : clock, synchronous active-low reset
//   en          : timer enable; 0 clears the hold count and the timeout flag
//   cnt_zero    : phase counter is at 0 (start of the high phase)
//   scl_in      : synchronised SCL bus level
//   to_limit_i  : timeout in held cycles, 0 disables
//   hold_req    : freeze the phase counter this cycle
//   stretching  : level, a slave is holding SCL low
//   stretch_to  : sticky timeout flag
module iic_stretch_monitor #(
  parameter bit          STRETCH_EN = 1'b1,
  parameter int unsigned TO_W       = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            cnt_zero,
  input  logic            scl_in,
  input  logic [TO_W-1:0] to_limit_i,
  output logic            hold_req,
  output logic            stretching,
  output logic            stretch_to
);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_q, to_d;

  assign hold_req   = STRETCH_EN & en & cnt_zero & ~scl_in;
  assign stretching = hold_req;
  assign stretch_to = to_q;

  always_comb begin
    to_cnt_d = '0;
    to_d     = to_q;
    if (!en) begin
      to_d = 1'b0;
    end else if (hold_req) begin
      // Saturate so a very long stretch cannot wrap back under the limit.
      to_cnt_d = (&to_cnt_q) ? to_cnt_q : to_cnt_q + TO_W'(1);
      if ((to_limit_i != '0) && (to_cnt_d >= to_limit_i)) begin
        to_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_q     <= to_d;
    end
  end

endmodule

// File: rtl/iic_scl_timer.sv
// Runtime-programmable SCL timing generator for the IIC master.
// One SCL period is div_q clk cycles: high for div_q>>1 cycles, then low for the rest.
// Phase strobes are decoded directly from the registered counter.
//   clk, rst_n   : clock, synchronous active-low reset
//   en           : 1 runs SCL, 0 idles with SCL released
//   div_i        : new period in clk cycles, captured by div_load
//   div_load     : one-cycle strobe capturing div_i as the pending divisor
//   to_limit_i   : stretch timeout in clk cycles, 0 disables
//   scl_in       : synchronised SCL bus level
//   scl_o        : 1 releases SCL, 0 drives it low
//   rise, high_mid, fall, low_mid, period_done : single-cycle phase strobes
//   stretching   : counter held by a slave stretching SCL
//   stretch_to   : sticky stretch timeout
module iic_scl_timer
  import iic_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DIV_DEFAULT = 500,
  parameter bit          STRETCH_EN  = 1'b1,
  parameter int unsigned TO_W        = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_i,
  input  logic             div_load,
  input  logic [TO_W-1:0]  to_limit_i,
  input  logic             scl_in,
  output logic             scl_o,
  output logic             rise,
  output logic             high_mid,
  output logic             fall,
  output logic             low_mid,
  output logic             period_done,
  output logic             stretching,
  output logic             stretch_to
);

  localparam logic [CNT_W-1:0] DivReset = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] MinDiv   = CNT_W'(IIC_MIN_DIV);

  // StHold means the previous cycle was already held at cnt 0, so this period's rise
  // has been issued and must not repeat.
  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;

  logic [CNT_W-1:0] high_len, low_len, hm_pt, lm_pt, last_pt, pend_clamped;
  logic             cnt_zero, at_last, wrap, apply, hold_req, phase_active;
  iic_phase_t       phase;

  assign high_len     = div_q >> 1;
  assign low_len      = div_q - high_len;
  assign hm_pt        = high_len >> 1;
  assign lm_pt        = high_len + (low_len >> 1);
  assign last_pt      = div_q - CNT_W'(1);
  assign cnt_zero     = (cnt_q == '0);
  assign at_last      = (cnt_q >= last_pt);
  assign pend_clamped = (pend_q < MinDiv) ? MinDiv : pend_q;

  iic_stretch_monitor #(
    .STRETCH_EN (STRETCH_EN),
    .TO_W       (TO_W)
  ) u_stretch (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cnt_zero   (cnt_zero),
    .scl_in     (scl_in),
    .to_limit_i (to_limit_i),
    .hold_req   (hold_req),
    .stretching (stretching),
    .stretch_to (stretch_to)
  );

  // Counter FSM
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    phase_active = 1'b0;
    case (state_q)
      StIdle, StRun: phase_active = en;
      StHold:        phase_active = 1'b0;
      default:       phase_active = 1'b0;
    endcase
    if (!en) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (hold_req) begin
      state_d = StHold;
    end else begin
      state_d = StRun;
      cnt_d   = at_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Phase strobes; only rise can coincide with a held cycle since every other
  // point is past cnt 0 for any applied divisor.
  always_comb begin
    phase             = '0;
    phase.rise        = phase_active & cnt_zero;
    phase.high_mid    = phase_active & (cnt_q == hm_pt);
    phase.fall        = phase_active & (cnt_q == high_len);
    phase.low_mid     = phase_active & (cnt_q == lm_pt);
    phase.period_done = phase_active & at_last;
  end

  assign rise        = phase.rise;
  assign high_mid    = phase.high_mid;
  assign fall        = phase.fall;
  assign low_mid     = phase.low_mid;
  assign period_done = phase.period_done;
  assign scl_o       = ~en | (cnt_q < high_len);

  // Divisor reload: the pending value only lands on a period boundary or while idle,
  // and a load in the same cycle becomes the next pending value.
  assign wrap  = en & at_last & ~hold_req;
  assign apply = ~en | wrap;

  always_comb begin
    div_d    = div_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (apply && pend_v_q) begin
      div_d    = pend_clamped;
      pend_v_d = 1'b0;
    end
    if (div_load) begin
      pend_d   = div_i;
      pend_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      div_q    <= DivReset;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

endmodule

// File: tb/tb_iic_scl_timer.sv
// Bench for iic_scl_timer: directed scenarios plus random traffic, each cycle compared
// against a period-level reference model. Instance a honours stretching, b ignores it.
module tb_iic_scl_timer;

  localparam int CNT_W = 16;
  localparam int TO_W  = 20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [CNT_W-1:0] div_i;
  logic             div_load;
  logic [TO_W-1:0]  to_limit_i;
  logic             scl_in;

  // {scl_o, rise, high_mid, fall, low_mid, period_done, stretching, stretch_to}
  wire  [7:0]       out_a;
  wire  [7:0]       out_b;
  logic [7:0]       obs_a, obs_b;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc_n     = 0;

  always #5 clk = ~clk;

  iic_scl_timer #(
    .CNT_W(CNT_W), .DIV_DEFAULT(500), .STRETCH_EN(1'b1), .TO_W(TO_W)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .div_i(div_i), .div_load(div_load),
    .to_limit_i(to_limit_i), .scl_in(scl_in),
    .scl_o(out_a[7]), .rise(out_a[6]), .high_mid(out_a[5]), .fall(out_a[4]),
    .low_mid(out_a[3]), .period_done(out_a[2]), .stretching(out_a[1]),
    .stretch_to(out_a[0])
  );

  iic_scl_timer #(
    .CNT_W(CNT_W), .DIV_DEFAULT(500), .STRETCH_EN(1'b0), .TO_W(TO_W)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .div_i(div_i), .div_load(div_load),
    .to_limit_i(to_limit_i), .scl_in(scl_in),
    .scl_o(out_b[7]), .rise(out_b[6]), .high_mid(out_b[5]), .fall(out_b[4]),
    .low_mid(out_b[3]), .period_done(out_b[2]), .stretching(out_b[1]),
    .stretch_to(out_b[0])
  );

  // Reference model: position inside the SCL period plus bookkeeping.
  typedef struct {
    int pos;
    int div;
    int pend;
    bit pend_v;
    bit held;
    int to_cnt;
    bit to_flag;
  } mdl_t;

  mdl_t ma, mb;

  function automatic int clampd(int v);
    return (v < 4) ? 4 : v;
  endfunction

  function automatic mdl_t m_reset();
    mdl_t m;
    m.pos = 0; m.div = 500; m.pend = 0; m.pend_v = 0;
    m.held = 0; m.to_cnt = 0; m.to_flag = 0;
    return m;
  endfunction

  function automatic logic [7:0] m_out(mdl_t m, bit se);
    int         h, l;
    bit         first, hold;
    logic [7:0] o;
    if (!en) return {1'b1, 6'b0, m.to_flag};
    h     = m.div / 2;
    l     = m.div - h;
    hold  = se && (m.pos == 0) && !scl_in;
    first = !m.held;
    o[7]  = (m.pos < h);
    o[6]  = first && (m.pos == 0);
    o[5]  = first && (m.pos == h / 2);
    o[4]  = first && (m.pos == h);
    o[3]  = first && (m.pos == h + l / 2);
    o[2]  = first && (m.pos == m.div - 1);
    o[1]  = hold;
    o[0]  = m.to_flag;
    return o;
  endfunction

  function automatic mdl_t m_next(mdl_t m, bit se);
    int lim;
    lim = int'(to_limit_i);
    if (!en) begin
      m.pos = 0;
      if (m.pend_v) begin m.div = clampd(m.pend); m.pend_v = 0; end
      m.held = 0; m.to_cnt = 0; m.to_flag = 0;
    end else if (se && (m.pos == 0) && !scl_in) begin
      m.held = 1;
      m.to_cnt++;
      if (lim != 0 && m.to_cnt >= lim) m.to_flag = 1;
    end else begin
      m.held = 0; m.to_cnt = 0;
      if (m.pos == m.div - 1) begin
        m.pos = 0;
        if (m.pend_v) begin m.div = clampd(m.pend); m.pend_v = 0; end
      end else begin
        m.pos++;
      end
    end
    if (div_load) begin m.pend = int'(div_i); m.pend_v = 1; end
    return m;
  endfunction

  task automatic chk_v(input string tag, input logic [7:0] o, input logic [7:0] e);
    n_asserts++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc_n, o, e);
    end
  endtask

  task automatic chk_i(input string tag, input int o, input int e);
    n_asserts++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc_n, o, e);
    end
  endtask

  // Inputs are set before the call; outputs sampled at negedge, state advances at posedge.
  task automatic tick();
    @(negedge clk);
    obs_a = out_a;
    obs_b = out_b;
    if (rst_n) begin
      chk_v("model_a", out_a, m_out(ma, 1'b1));
      chk_v("model_b", out_b, m_out(mb, 1'b0));
      ma = m_next(ma, 1'b1);
      mb = m_next(mb, 1'b0);
    end else begin
      ma = m_reset();
      mb = m_reset();
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  // Runs one period of instance a starting on its rise cycle; offsets are from that rise.
  task automatic run_period(input string tag, input int load_at, input int load_val,
                            input int st, input int e_hm, input int e_fl, input int e_lm,
                            input int e_len, input int e_str);
    int hm, fl, lm, len, nrise, nstr;
    hm = -1; fl = -1; lm = -1; len = -1; nrise = 0; nstr = 0;
    for (int k = 0; k < 2000; k++) begin
      div_load = (k == load_at);
      if (k == load_at) div_i = CNT_W'(load_val);
      scl_in = (k >= st);
      tick();
      if (obs_a[6]) nrise++;
      if (obs_a[1]) nstr++;
      if (obs_a[5] && hm < 0) hm = k;
      if (obs_a[4] && fl < 0) fl = k;
      if (obs_a[3] && lm < 0) lm = k;
      if (obs_a[2]) begin len = k + 1; break; end
    end
    div_load = 1'b0;
    scl_in   = 1'b1;
    chk_i({tag, "_high_mid"}, hm, e_hm);
    chk_i({tag, "_fall"}, fl, e_fl);
    chk_i({tag, "_low_mid"}, lm, e_lm);
    chk_i({tag, "_len"}, len, e_len);
    chk_i({tag, "_rises"}, nrise, 1);
    chk_i({tag, "_stretch"}, nstr, e_str);
  endtask

  task automatic load_idle(input int v);
    en = 1'b0; div_i = CNT_W'(v); div_load = 1'b1;
    tick();
    div_load = 1'b0;
    tick();
    en = 1'b1;
  endtask

  initial begin
    int rises_b, str_b;
    rst_n = 1'b0; en = 1'b0; div_i = '0; div_load = 1'b0; scl_in = 1'b1; to_limit_i = '0;
    ma = m_reset(); mb = m_reset();
    tick();
    rst_n = 1'b1;
    chk_v("reset_a", out_a, 8'h80);
    chk_v("reset_b", out_b, 8'h80);

    // Divisor 8
    load_idle(8);
    run_period("div8_p1", -1, 0, 0, 2, 4, 6, 8, 0);
    run_period("div8_p2", -1, 0, 0, 2, 4, 6, 8, 0);

    // Default divisor after reset
    en = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; en = 1'b1;
    run_period("default", -1, 0, 0, 125, 250, 375, 500, 0);

    // Mid-period load of 2 waits for the wrap, then clamps to 4
    load_idle(9);
    run_period("div9", 4, 2, 0, 2, 4, 6, 9, 0);
    run_period("clamp4", -1, 0, 0, 1, 2, 3, 4, 0);

    // Ten-cycle stretch at the start of the period
    load_idle(8);
    run_period("stretch", -1, 0, 10, 12, 14, 16, 18, 10);

    // Stuck-low bus with a five-cycle timeout; instance b keeps free-running
    to_limit_i = TO_W'(5);
    scl_in = 1'b0;
    rises_b = 0; str_b = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      chk_i("to_flag", int'(obs_a[0]), (i >= 5) ? 1 : 0);
      if (obs_a[1] !== 1'b1) chk_i("to_stretching", int'(obs_a[1]), 1);
      if (obs_b[6]) rises_b++;
      if (obs_b[1]) str_b++;
    end
    chk_i("nostretch_rises", rises_b, 4);
    chk_i("nostretch_level", str_b, 0);
    en = 1'b0;
    tick();
    chk_v("to_drop_en0", obs_a, 8'h81);
    tick();
    chk_v("to_drop_en1", obs_a, 8'h80);
    scl_in = 1'b1; to_limit_i = '0;

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      en       = ($urandom_range(0, 24) != 0);
      div_load = ($urandom_range(0, 29) == 0);
      div_i    = CNT_W'($urandom_range(0, 20));
      scl_in   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) to_limit_i = TO_W'($urandom_range(0, 6));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
